// File: rtl/ftdi_status_pio_pkg.sv
// Shared constants for the FTDI UMFT601A status input PIO: register map,
// capture polarity encodings, arm counter width and the per-bit edge selector.
package ftdi_status_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Wide enough for SYNC_STAGES+1 with any practical synchronizer depth.
  localparam int ARM_CNT_W = 6;

  function automatic logic edge_hit(input logic [1:0] etype, input logic cur, input logic prev);
    logic hit;
    case (etype)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_ANY:  hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ftdi_status_pio_bit_cond.sv
// One status bit: multi-flop synchronizer followed, when
// FTDI_STATUS_PIO_DEBOUNCE_EN is defined, by a stable-count debouncer.
module ftdi_status_pio_bit_cond
  import ftdi_status_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;

  // Synchronizer shift chain; the last stage is the first usable sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in_bit};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

`ifdef FTDI_STATUS_PIO_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_r;
  logic            db_level_r;

  // Debouncer: follow the synchronized bit only after it disagrees for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_r   <= {DB_W{1'b0}};
      db_level_r <= 1'b0;
    end else if (sync_s == db_level_r) begin
      db_cnt_r   <= {DB_W{1'b0}};
      db_level_r <= db_level_r;
    end else if (db_cnt_r == DB_LAST) begin
      db_cnt_r   <= {DB_W{1'b0}};
      db_level_r <= sync_s;
    end else begin
      db_cnt_r   <= db_cnt_r + DB_W'(1);
      db_level_r <= db_level_r;
    end
  end

  assign level = db_level_r;
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
  assign level = sync_s;
`endif

endmodule

// File: rtl/ftdi_umft601a_status_pio_in.sv
// Avalon-MM input PIO for UMFT601A status pins: level, W1C edge capture and
// masked level IRQ. Optional debounce enabled by FTDI_STATUS_PIO_DEBOUNCE_EN.
module ftdi_umft601a_status_pio_in
  import ftdi_status_pio_pkg::*;
#(
  parameter int          WIDTH           = 4,
  parameter int          SYNC_STAGES     = 2,
  parameter int          EDGE_TYPE       = 0,
  parameter logic [31:0] IRQ_RESET_MASK  = 32'h0000_0000,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0]           EDGE_SEL = EDGE_TYPE[1:0];
  localparam logic [ARM_CNT_W-1:0] ARM_DONE = ARM_CNT_W'(SYNC_STAGES + 1);
  localparam logic [WIDTH-1:0]     MASK_RST = IRQ_RESET_MASK[WIDTH-1:0];

  logic [WIDTH-1:0]     level_s;
  logic [WIDTH-1:0]     prev_r;
  logic [WIDTH-1:0]     edge_s;
  logic [WIDTH-1:0]     capture_r;
  logic [WIDTH-1:0]     capture_next_s;
  logic [WIDTH-1:0]     clear_s;
  logic [WIDTH-1:0]     mask_r;
  logic [WIDTH-1:0]     mask_next_s;
  logic [ARM_CNT_W-1:0] arm_cnt_r;
  logic                 armed_s;
  logic                 wr_s;
  logic [31:0]          rd_mux_s;
  logic                 unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    ftdi_status_pio_bit_cond #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
      .clk    (clk),
      .reset  (reset),
      .in_bit (in_port[gi]),
      .level  (level_s[gi])
    );
  end

  // Arm counter: holds off capture until the reset-zeroed chain has filled with real samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt_r <= {ARM_CNT_W{1'b0}};
    end else if (!armed_s) begin
      arm_cnt_r <= arm_cnt_r + ARM_CNT_W'(1);
    end else begin
      arm_cnt_r <= arm_cnt_r;
    end
  end

  assign armed_s = (arm_cnt_r == ARM_DONE);

  // Edge detect on the conditioned level against its one-cycle-old copy.
  always_comb begin
    edge_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      edge_s[i] = edge_hit(EDGE_SEL, level_s[i], prev_r[i]);
    end
  end

  // Write decode; a new edge is ORed in after the clear so it is never lost.
  always_comb begin
    wr_s        = chipselect & ~write_n;
    clear_s     = {WIDTH{1'b0}};
    mask_next_s = mask_r;
    if (wr_s && (address == ADDR_EDGE)) begin
      clear_s = writedata[WIDTH-1:0];
    end else begin
      clear_s = {WIDTH{1'b0}};
    end
    if (wr_s && (address == ADDR_MASK)) begin
      mask_next_s = writedata[WIDTH-1:0];
    end else begin
      mask_next_s = mask_r;
    end
    if (armed_s) begin
      capture_next_s = (capture_r & ~clear_s) | edge_s;
    end else begin
      capture_next_s = capture_r & ~clear_s;
    end
  end

  // Read mux, zero-extended; the reserved word falls through to zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      ADDR_DATA: rd_mux_s[WIDTH-1:0] = level_s;
      ADDR_MASK: rd_mux_s[WIDTH-1:0] = mask_r;
      ADDR_EDGE: rd_mux_s[WIDTH-1:0] = capture_r;
      default:   rd_mux_s            = 32'd0;
    endcase
  end

  // Register state, registered read data and registered interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r    <= {WIDTH{1'b0}};
      capture_r <= {WIDTH{1'b0}};
      mask_r    <= MASK_RST;
      irq       <= 1'b0;
      readdata  <= 32'd0;
    end else begin
      prev_r    <= level_s;
      capture_r <= capture_next_s;
      mask_r    <= mask_next_s;
      irq       <= |(capture_r & mask_r);
      readdata  <= rd_mux_s;
    end
  end

endmodule
